// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 loader: FSM encoding, colour-word slot
// positions and the idle-timeout derivation.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCALE   = 2'd1,
    ST_WRITE   = 2'd2
  } loader_state_e;

  // Wire order is G,R,B; the first byte lands in the top slot.
  localparam int unsigned G_MSB = 23;
  localparam int unsigned G_LSB = 16;
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

  localparam int unsigned RGB_W = 24;

  function automatic int unsigned t_idle_cycles(input int unsigned clk_mhz,
                                                input int unsigned idle_us);
    return clk_mhz * idle_us;
  endfunction

endpackage

// File: rtl/ws2812_scale.sv
// Combinational 8-bit channel scaler: (c * (brightness + 1)) >> 8.
// Only built when WS2812_LOADER_BRIGHTNESS_EN is defined.
`ifdef WS2812_LOADER_BRIGHTNESS_EN
module ws2812_scale (
  input  logic [7:0] chan_i,
  input  logic [7:0] brightness_i,
  output logic [7:0] scaled_c_o
);

  logic [15:0] prod_c;

  // 255 * 256 still fits in 16 bits, so the upper byte is the full result.
  assign prod_c     = 16'(chan_i) * (16'(brightness_i) + 16'd1);
  assign scaled_c_o = 8'(prod_c >> 8);

endmodule
`endif

// File: rtl/ws2812_loader.sv
// Byte-stream to ws2812 LED-memory loader: assembles G,R,B bytes into 24-bit
// words and strobes them into the driver. Optional brightness scaling under
// WS2812_LOADER_BRIGHTNESS_EN.
module ws2812_loader
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned CLK_MHZ  = 12,
  parameter int unsigned IDLE_US  = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        frame_start,
  input  logic [7:0]  brightness,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done
);

  localparam int unsigned T_IDLE = t_idle_cycles(CLK_MHZ, IDLE_US);
  localparam int unsigned IDLE_W = $clog2(T_IDLE + 1);
  localparam int unsigned IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(T_IDLE);

  loader_state_e     state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [RGB_W-1:0]  word_q, word_d;
  logic              fs_pend_q, fs_pend_d;
  logic              byte_ready_q, byte_ready_d;
  logic              write_q, write_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        led_num_q, led_num_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;

  logic              accept_c;
  logic              busy_c;
  logic              timeout_c;
  logic              realign_c;
  logic [1:0]        phase_eff_c;
  logic [IDX_W-1:0]  idx_eff_c;
  logic [IDX_W-1:0]  idx_inc_c;
  logic [RGB_W-1:0]  scaled_c;

`ifdef WS2812_LOADER_BRIGHTNESS_EN
  ws2812_scale u_scale_g (
    .chan_i       (word_q[G_MSB:G_LSB]),
    .brightness_i (brightness),
    .scaled_c_o   (scaled_c[G_MSB:G_LSB])
  );
  ws2812_scale u_scale_r (
    .chan_i       (word_q[R_MSB:R_LSB]),
    .brightness_i (brightness),
    .scaled_c_o   (scaled_c[R_MSB:R_LSB])
  );
  ws2812_scale u_scale_b (
    .chan_i       (word_q[B_MSB:B_LSB]),
    .brightness_i (brightness),
    .scaled_c_o   (scaled_c[B_MSB:B_LSB])
  );
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign scaled_c          = word_q;
`endif

  // A pending realignment (explicit pulse or stale partial LED) is applied
  // before the byte accepted in the same cycle, so that byte becomes G of LED 0.
  assign accept_c    = (state_q == ST_COLLECT) && byte_valid && byte_ready_q;
  assign busy_c      = (phase_q != 2'd0) || (idx_q != '0);
  assign timeout_c   = busy_c && (idle_q == IDLE_MAX);
  assign realign_c   = frame_start || timeout_c;
  assign phase_eff_c = realign_c ? 2'd0 : phase_q;
  assign idx_eff_c   = realign_c ? '0 : idx_q;
  assign idx_inc_c   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    idle_d       = idle_q;
    word_d       = word_q;
    fs_pend_d    = fs_pend_q;
    byte_ready_d = byte_ready_q;
    write_d      = 1'b0;
    frame_done_d = 1'b0;
    led_num_d    = led_num_q;
    rgb_d        = rgb_q;

    // Idle counter saturates at T_IDLE and only runs mid-frame.
    if (accept_c || frame_start) begin
      idle_d = '0;
    end else if (busy_c && (idle_q != IDLE_MAX)) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    unique case (state_q)
      ST_COLLECT: begin
        byte_ready_d = 1'b1;
        fs_pend_d    = 1'b0;
        phase_d      = phase_eff_c;
        idx_d        = idx_eff_c;
        if (accept_c) begin
          unique case (phase_eff_c)
            2'd0:    word_d[G_MSB:G_LSB] = byte_data;
            2'd1:    word_d[R_MSB:R_LSB] = byte_data;
            default: word_d[B_MSB:B_LSB] = byte_data;
          endcase
          phase_d = phase_eff_c + 2'd1;
          if (phase_eff_c == 2'd2) begin
            phase_d      = 2'd0;
            byte_ready_d = 1'b0;
`ifdef WS2812_LOADER_BRIGHTNESS_EN
            state_d      = ST_SCALE;
`else
            state_d      = ST_WRITE;
            write_d      = 1'b1;
            rgb_d        = {word_q[G_MSB:R_LSB], byte_data};
            led_num_d    = 8'(idx_eff_c);
            frame_done_d = (idx_eff_c == LAST_IDX);
`endif
          end
        end
      end

      ST_SCALE: begin
        state_d      = ST_WRITE;
        write_d      = 1'b1;
        rgb_d        = scaled_c;
        led_num_d    = 8'(idx_q);
        frame_done_d = (idx_q == LAST_IDX);
        if (frame_start) fs_pend_d = 1'b1;
      end

      ST_WRITE: begin
        state_d      = ST_COLLECT;
        byte_ready_d = 1'b1;
        phase_d      = 2'd0;
        fs_pend_d    = 1'b0;
        idx_d        = (frame_start || fs_pend_q) ? '0 : idx_inc_c;
      end

      default: begin
        state_d      = ST_COLLECT;
        byte_ready_d = 1'b1;
        phase_d      = 2'd0;
        idx_d        = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_COLLECT;
      phase_q      <= 2'd0;
      idx_q        <= '0;
      idle_q       <= '0;
      word_q       <= '0;
      fs_pend_q    <= 1'b0;
      byte_ready_q <= 1'b1;
      write_q      <= 1'b0;
      frame_done_q <= 1'b0;
      led_num_q    <= 8'd0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      idle_q       <= idle_d;
      word_q       <= word_d;
      fs_pend_q    <= fs_pend_d;
      byte_ready_q <= byte_ready_d;
      write_q      <= write_d;
      frame_done_q <= frame_done_d;
      led_num_q    <= led_num_d;
      rgb_q        <= rgb_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign write      = write_q;
  assign frame_done = frame_done_q;
  assign led_num    = led_num_q;
  assign rgb_data   = rgb_q;

endmodule

// File: tb/tb_ws2812_loader.sv
// Directed self-checking bench for ws2812_loader (default parameters).
module tb_ws2812_loader;

`ifdef WS2812_LOADER_BRIGHTNESS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NUM_LEDS = 8;
  localparam int T_IDLE   = 12 * 100;
  localparam int LED_CYC  = LAT + 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        frame_start;
  logic [7:0]  brightness;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int stray_fd = 0;
  int q_led[$];
  int q_rgb[$];
  int q_fd[$];
  int q_cyc[$];

  ws2812_loader #(.NUM_LEDS(NUM_LEDS), .CLK_MHZ(12), .IDLE_US(100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_start (frame_start),
    .brightness  (brightness),
    .rgb_data    (rgb_data),
    .led_num     (led_num),
    .write       (write),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe observed mid-cycle.
  always @(negedge clk) begin
    if (write) begin
      q_led.push_back(int'(led_num));
      q_rgb.push_back(int'(rgb_data));
      q_fd.push_back(int'(frame_done));
      q_cyc.push_back(cyc);
    end
    if (frame_done && !write) stray_fd++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_led.delete();
    q_rgb.delete();
    q_fd.delete();
    q_cyc.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte; frame_start is pulsed only in the accepting cycle.
  task automatic send(input logic [7:0] b, input logic fs);
    logic accepted;
    accepted   = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted    = byte_ready;
      frame_start = fs && byte_ready;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
    end
    byte_valid = 1'b0;
    if (!accepted) check("byte_accept", {31'b0, accepted}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, byte_ready}, 32'd1);
    check({tag, "_write"}, {31'b0, write}, 32'd0);
    check({tag, "_fdone"}, {31'b0, frame_done}, 32'd0);
    check({tag, "_led"}, 32'(led_num), 32'd0);
    check({tag, "_rgb"}, 32'(rgb_data), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    byte_data   = 8'h00;
    byte_valid  = 1'b0;
    frame_start = 1'b0;
    brightness  = 8'd255;
    step(3);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    step(2);

    // Single LED: latency, data and ready window.
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    for (int k = 1; k < LAT; k++) begin
      check("lat_early_write", {31'b0, write}, 32'd0);
      check("lat_early_ready", {31'b0, byte_ready}, 32'd0);
      step(1);
    end
    check("t1_write", {31'b0, write}, 32'd1);
    check("t1_ready", {31'b0, byte_ready}, 32'd0);
    check("t1_led", 32'(led_num), 32'd0);
    check("t1_rgb", 32'(rgb_data), 32'h102030);
    check("t1_fdone", {31'b0, frame_done}, 32'd0);
    step(1);
    check("t1_post_write", {31'b0, write}, 32'd0);
    check("t1_post_ready", {31'b0, byte_ready}, 32'd1);
    check("t1_hold_rgb", 32'(rgb_data), 32'h102030);

    // Full frame after realignment, then wrap to LED 0.
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    clear_log();
    for (int i = 0; i < 3 * NUM_LEDS; i++) send(8'(8'h40 + i), 1'b0);
    step(LAT + 2);
    check("frame_count", q_led.size(), NUM_LEDS);
    for (int j = 0; j < NUM_LEDS; j++) begin
      check($sformatf("frame_led%0d", j), q_led[j], j);
      check($sformatf("frame_rgb%0d", j), q_rgb[j],
            {8'h00, 8'(8'h40 + 3*j), 8'(8'h41 + 3*j), 8'(8'h42 + 3*j)});
      check($sformatf("frame_fd%0d", j), q_fd[j], (j == NUM_LEDS - 1) ? 1 : 0);
      if (j > 0) check($sformatf("frame_gap%0d", j), q_cyc[j] - q_cyc[j-1], LED_CYC);
    end
    clear_log();
    send(8'hE1, 1'b0);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    step(LAT + 2);
    check("wrap_count", q_led.size(), 1);
    check("wrap_led", q_led[0], 0);
    check("wrap_rgb", q_rgb[0], 32'hE1E2E3);
    check("wrap_fd", q_fd[0], 0);

    // Idle timeout discards a partial LED.
    clear_log();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    step(T_IDLE + 5);
    check("idle_nowrite", q_led.size(), 0);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b0);
    step(LAT + 2);
    check("idle_count", q_led.size(), 1);
    check("idle_led", q_led[0], 0);
    check("idle_rgb", q_rgb[0], 32'hB1B2B3);

    // frame_start coincident with the 5th byte.
    clear_log();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    step(LAT + 2);
    check("fs_count", q_led.size(), 2);
    check("fs_led_a", q_led[0], 1);
    check("fs_rgb_a", q_rgb[0], 32'h010203);
    check("fs_led_b", q_led[1], 0);
    check("fs_rgb_b", q_rgb[1], 32'h556677);

`ifdef WS2812_LOADER_BRIGHTNESS_EN
    clear_log();
    brightness = 8'd127;
    send(8'hFF, 1'b0);
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    step(LAT + 2);
    check("bri127_rgb", q_rgb[0], 32'h7F4000);
    clear_log();
    brightness = 8'd255;
    send(8'hFF, 1'b0);
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    step(LAT + 2);
    check("bri255_rgb", q_rgb[0], 32'hFF8001);
`endif

    // Asynchronous reset between the 2nd and 3rd byte.
    clear_log();
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step(1);
    reset_n = 1'b1;
    step(1);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    step(LAT + 2);
    check("rst_count", q_led.size(), 1);
    check("rst_led", q_led[0], 0);
    check("rst_rgb", q_rgb[0], 32'hC1C2C3);

    check("stray_frame_done", stray_fd, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ws2812_loader.md
# ws2812_loader

Upstream feeder for the `ws2812` driver. Accepts a byte stream (valid/ready) in wire order G,R,B per LED, assembles 24-bit colour words and issues `write`/`led_num`/`rgb_data` strobes directly into the driver's LED memory. Frame alignment comes from an explicit `frame_start` pulse or an idle timeout. Typical source is a UART receiver or an SPI slave.

## Interface
- `NUM_LEDS`, 8: LEDs per frame; must match the driver. Range 1..256.
- `CLK_MHZ`, 12: clock frequency in MHz.
- `IDLE_US`, 100: inter-byte gap in µs that forces resynchronisation. `T_IDLE = CLK_MHZ*IDLE_US` cycles.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `byte_data` in 8: stream byte.
- `byte_valid` in 1: `byte_data` is valid.
- `byte_ready` out 1: loader can accept a byte. A transfer occurs when `byte_valid && byte_ready`.
- `frame_start` in 1: single-cycle pulse that realigns to LED 0, byte phase 0.
- `brightness` in 8: global scale, used only when `BRIGHTNESS_EN` is defined.
- `rgb_data` out 24: colour word to the driver. First byte goes to [23:16], second to [15:8], third to [7:0].
- `led_num` out 8: target LED index. Upper bits beyond `$clog2(NUM_LEDS)` are 0.
- `write` out 1: one-cycle write strobe to the driver.
- `frame_done` out 1: one-cycle pulse, coincident with the `write` for LED `NUM_LEDS-1`.

## Operation
- State machine: COLLECT → (SCALE) → WRITE → COLLECT.
- **COLLECT**
  - `byte_ready`=1.
  - A 2-bit byte phase counts 0,1,2. Each accepted byte is latched into the slot for the current phase.
  - Accepting the byte at phase 2 moves to SCALE (`BRIGHTNESS_EN`) or to WRITE.
- **SCALE**
  - `byte_ready`=0.
  - Each channel becomes `(c*(brightness+1))>>8`, computed in 16 bits with the upper 8 bits kept.
  - `brightness`=255 leaves the colour unchanged. `brightness`=0 maps 255→0.
- **WRITE**
  - `byte_ready`=0, `write`=1, with the current `led_num` and `rgb_data`.
  - Then `led_num` increments. From `NUM_LEDS-1` it wraps to 0, and `frame_done`=1 in that same WRITE cycle.
  - Phase returns to 0.
  - Bytes beyond `NUM_LEDS*3` wrap to LED 0. They are not dropped and raise no error.
- **Idle timeout**
  - A counter of `$clog2(T_IDLE+1)` bits clears on every accepted byte and saturates at `T_IDLE`.
  - It counts only while phase≠0 or LED index≠0.
  - On reaching `T_IDLE`: phase and index go to 0 and the partial LED is discarded (no `write`).
- **`frame_start`**
  - Phase, index and the idle counter go to 0.
  - In SCALE/WRITE the pending write still completes first. The realignment applies on return to COLLECT, which overrides the index increment.
  - If it coincides with an accepted byte in COLLECT, that byte is taken as phase 0 of LED 0.
- **Reset**: asynchronous and effective mid-frame. Any partial LED or pending write is lost, with no `write` emitted.

## Timing
- Reset values:
  - `byte_ready`=1, `write`=0, `frame_done`=0.
  - `led_num`=0, `rgb_data`=0.
  - State COLLECT, phase 0.
- `byte_ready` is a registered output and does not depend combinationally on `byte_valid`.
- Write latency, measured from the cycle the third byte is accepted:
  - `write` is asserted 1 cycle later without `BRIGHTNESS_EN`, 2 cycles later with it.
- Throughput:
  - 4 cycles per LED at full input rate without `BRIGHTNESS_EN`, 5 with it.
  - `byte_ready` is low only in SCALE/WRITE.
- `rgb_data`/`led_num` hold their last written values between strobes.
- `brightness` is sampled in SCALE only.

## Configuration
- `WS2812_LOADER_BRIGHTNESS_EN` defined:
  - The SCALE state and the `brightness` input are active.
  - Write latency is 2.
- Not defined:
  - SCALE is skipped and `brightness` is ignored (left unconnected internally).
  - `rgb_data` is the raw input bytes and write latency is 1.

## Structure
- Package `ws2812_pkg`:
  - loader state encoding (COLLECT/SCALE/WRITE);
  - byte-slot bit positions (G=23:16, R=15:8, B=7:0);
  - the `T_IDLE` derivation.
- Sub-module `ws2812_scale`: a combinational 8-bit channel scaler, instantiated once per channel, present only under the macro.
- The rest is a flat FSM plus counters.

## Test plan
- Reset, then bytes 0x10,0x20,0x30 back-to-back:
  - `write` 1 cycle after the third byte (2 with the macro);
  - `led_num`=0, `rgb_data`=0x102030;
  - `byte_ready` low exactly during SCALE/WRITE.
- Stream 24 bytes with `NUM_LEDS`=8:
  - `led_num` goes 0..7;
  - `frame_done` coincides only with the `led_num`=7 write;
  - a 25th-27th byte group writes `led_num`=0.
- Send 2 bytes, idle `T_IDLE` cycles, then 3 bytes:
  - there is no write for the partial LED;
  - the next write targets `led_num`=0 with the three new bytes.
- `frame_start` asserted together with the 5th byte:
  - that byte becomes G of LED 0;
  - after two more bytes, `write` with `led_num`=0.
- With the macro: `brightness`=127, bytes 0xFF,0x80,0x01 → `rgb_data`=0x7F4000. With `brightness`=255 → 0xFF8001.
- Assert `reset_n` low for 1 cycle between the 2nd and 3rd byte:
  - outputs return to their reset values immediately;
  - no `write` occurs;
  - the next three bytes write LED 0.
